id_ex_stage: RTL
================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter N, default 32, datapath width.
REQ-002 Parameter RW, default 4, register-index width (16 registers).
REQ-003 Clock and reset: one clock; reset is synchronous and active-high; ports listed below.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 in_valid  in  1  fetch stage presents instr.
REQ-007 in_ready  out  1  stage accepts instr this cycle.
REQ-008 instr  in  32  [31:27] opcode, [26:23] rd, [22:19] rs1, [18:15] rs2, [14] I, [13:0] imm14.
REQ-009 rs1_addr, rs2_addr  out  RW  combinational register-file read addresses = instr fields.
REQ-010 rd1, rd2  in  N  register-file read data, same cycle.
REQ-011 fwd1_en, fwd1_rd, fwd1_data  in  1/RW/N  EX/MEM result forward.
REQ-012 fwd2_en, fwd2_rd, fwd2_data  in  1/RW/N  MEM/WB result forward.
REQ-013 flush  in  1  discard held and incoming instruction (taken branch).
REQ-014 out_valid  out  1  registered outputs hold a live instruction.
REQ-015 out_ready  in  1  ALU/EX stage consumes this cycle.
REQ-016 alu_ctrl  out  5  registered opcode for the ALU.
REQ-017 src_A, src_B  out  N  registered ALU operands.
REQ-018 dest  out  RW  registered rd; reg_wr, mem_rd, mem_wr, is_branch  out  1 each  registered controls.
REQ-019 illegal  out  1  one-cycle pulse when an unsupported opcode is accepted.

Function
REQ-020 Legal opcodes SHALL be 1,2,3,4,9,10,11,12,17,19,25-30; all others illegal.
REQ-021 Output register SHALL load when (!out_valid || out_ready); otherwise all outputs hold.
REQ-022 in_ready SHALL equal load-enable AND NOT hazard (REQ-027); a transfer occurs when in_valid && in_ready.
REQ-023 Operand select per source: fwd1 match (en && rd==rs) first, then fwd2 match, else rd1/rd2.
REQ-024 imm SHALL be imm14 sign-extended to N; src_B = I ? imm : rs2 value; src_A = rs1 value, except opcode 4 with I=1: src_A = imm.
REQ-025 Opcodes 17/19 SHALL force src_B = imm; 19 also drives rs2 value via src_A? No: 19 sets src_A = rs1 (base), store data is not carried (out of scope).
REQ-026 Controls: reg_wr for 1-4, 9-12, 17; mem_rd for 17; mem_wr for 19; is_branch for 25-30.
REQ-027 Load-use hazard: out_valid && mem_rd && reg_wr && dest matches an rs read by incoming valid instr; stage SHALL load a bubble (out_valid=0) and hold in_ready=0 for exactly that cycle.
REQ-028 Illegal opcode SHALL be accepted, produce a bubble (out_valid=0), and pulse illegal for one cycle.
REQ-029 flush SHALL, on that edge, clear out_valid and drop any incoming instruction; in_ready=1 during flush; flush beats hazard and out_ready.
REQ-030 Latency: accepted instruction appears on outputs one cycle later; throughput one per cycle without hazard/backpressure.
REQ-031 While out_valid && !out_ready, outputs SHALL be stable bit-for-bit.

Reset
REQ-032 On rst: out_valid=0, alu_ctrl=0, src_A=src_B=0, dest=0, all controls=0, illegal=0; in_ready=0 during rst.
REQ-033 rst mid-stall or mid-hazard SHALL discard the held instruction; no state survives.

Structure
REQ-034 Opcode constants, field positions and a decoded-control struct SHALL live in shared package cpu_pkg, also used by the ALU.
REQ-035 One sub-module fwd_mux (per-operand forwarding select), instantiated twice.

Verification
REQ-036 ADD r3,r1,r2 with rd1=5, rd2=7 -> next cycle alu_ctrl=1, src_A=5, src_B=7, reg_wr=1, out_valid=1.
REQ-037 Both forwards hit rs1=2 (fwd1_data=0xAA, fwd2_data=0xBB) -> src_A=0xAA.
REQ-038 LDR r4 held, next SUB reads r4 -> one bubble, in_ready=0 one cycle, SUB issues cycle after.
REQ-039 out_ready=0 for 3 cycles with MOV imm=-1 -> src_A=0xFFFFFFFF stable, in_ready=0 throughout.
REQ-040 flush asserted with valid held and incoming -> next cycle out_valid=0, neither instruction reappears.
REQ-041 Opcode 5 accepted -> illegal pulse 1 cycle, out_valid=0; rst asserted mid-stall -> all outputs 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg -- shared CPU definitions
// Purpose : instruction field positions, opcode constants and the decoded
//           control struct used by the ID/EX stage and by the ALU.
// Contents: field localparams, opcode_e, ctrl_t, decode().
// -----------------------------------------------------------------------------
package cpu_pkg;

    // Instruction field layout (32-bit instruction word)
    localparam int INSTR_W = 32;
    localparam int OPC_LSB = 27;
    localparam int OPC_W   = 5;
    localparam int RD_LSB  = 23;
    localparam int RS1_LSB = 19;
    localparam int RS2_LSB = 15;
    localparam int IMM_BIT = 14;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = 14;

    typedef enum logic [4:0] {
        OP_ADD  = 5'd1,
        OP_SUB  = 5'd2,
        OP_AND  = 5'd3,
        OP_MOV  = 5'd4,
        OP_OR   = 5'd9,
        OP_XOR  = 5'd10,
        OP_SHL  = 5'd11,
        OP_SHR  = 5'd12,
        OP_LDR  = 5'd17,
        OP_STR  = 5'd19,
        OP_BEQ  = 5'd25,
        OP_BNE  = 5'd26,
        OP_BLT  = 5'd27,
        OP_BGE  = 5'd28,
        OP_BLTU = 5'd29,
        OP_BGEU = 5'd30
    } opcode_e;

    // Decoded controls; the *_imm and uses_* flags steer operand selection
    // and tell the hazard logic which source registers are really read.
    typedef struct packed {
        logic legal;
        logic reg_wr;
        logic mem_rd;
        logic mem_wr;
        logic is_branch;
        logic a_is_imm;
        logic b_is_imm;
        logic uses_rs1;
        logic uses_rs2;
    } ctrl_t;

    function automatic ctrl_t decode(input logic [4:0] opc, input logic imm_sel);
        ctrl_t c;
        c = '0;
        case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
                c.legal  = 1'b1;
                c.reg_wr = 1'b1;
            end
            OP_MOV: begin
                c.legal    = 1'b1;
                c.reg_wr   = 1'b1;
                c.a_is_imm = imm_sel;   // MOV #imm routes the immediate to A
            end
            OP_LDR: begin
                c.legal    = 1'b1;
                c.reg_wr   = 1'b1;
                c.mem_rd   = 1'b1;
                c.b_is_imm = 1'b1;      // base + offset
            end
            OP_STR: begin
                c.legal    = 1'b1;
                c.mem_wr   = 1'b1;
                c.b_is_imm = 1'b1;      // base + offset; store data not carried
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                c.legal     = 1'b1;
                c.is_branch = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        c.b_is_imm = c.b_is_imm | imm_sel;
        c.uses_rs1 = ~c.a_is_imm;
        c.uses_rs2 = ~c.b_is_imm;
        return c;
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// -----------------------------------------------------------------------------
// fwd_mux -- forwarding select for one source operand
// Purpose : picks the newest value of register rs: EX/MEM forward first,
//           then MEM/WB forward, otherwise the register-file read data.
// Ports   : rs (source index), rf_data, fwd1_en/rd/data, fwd2_en/rd/data,
//           sel_data (selected operand value).
// -----------------------------------------------------------------------------
module fwd_mux #(
    parameter int N  = 32,
    parameter int RW = 4
) (
    input  logic [RW-1:0] rs,
    input  logic [N-1:0]  rf_data,
    input  logic          fwd1_en,
    input  logic [RW-1:0] fwd1_rd,
    input  logic [N-1:0]  fwd1_data,
    input  logic          fwd2_en,
    input  logic [RW-1:0] fwd2_rd,
    input  logic [N-1:0]  fwd2_data,
    output logic [N-1:0]  sel_data
);

    // Priority select: the younger EX/MEM result wins over MEM/WB
    always_comb begin
        sel_data = rf_data;
        if (fwd1_en && (fwd1_rd == rs)) begin
            sel_data = fwd1_data;
        end else if (fwd2_en && (fwd2_rd == rs)) begin
            sel_data = fwd2_data;
        end else begin
            sel_data = rf_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage -- decode / operand-fetch pipeline register feeding the ALU
// Purpose : decodes the incoming instruction, reads and forwards operands,
//           detects load-use hazards and registers everything for EX.
// Ports   : clk, rst (sync, active-high)
//           in_valid/in_ready/instr        : from fetch
//           rs1_addr/rs2_addr, rd1/rd2     : register-file read port
//           fwd1_* (EX/MEM), fwd2_* (MEM/WB): result forwarding
//           flush                          : taken-branch kill
//           out_valid/out_ready, alu_ctrl, src_A, src_B, dest,
//           reg_wr, mem_rd, mem_wr, is_branch : to EX
//           illegal                        : one-cycle unsupported-opcode pulse
// -----------------------------------------------------------------------------
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int N  = 32,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   instr,
    output logic [RW-1:0] rs1_addr,
    output logic [RW-1:0] rs2_addr,
    input  logic [N-1:0]  rd1,
    input  logic [N-1:0]  rd2,
    input  logic          fwd1_en,
    input  logic [RW-1:0] fwd1_rd,
    input  logic [N-1:0]  fwd1_data,
    input  logic          fwd2_en,
    input  logic [RW-1:0] fwd2_rd,
    input  logic [N-1:0]  fwd2_data,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [4:0]    alu_ctrl,
    output logic [N-1:0]  src_A,
    output logic [N-1:0]  src_B,
    output logic [RW-1:0] dest,
    output logic          reg_wr,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic          is_branch,
    output logic          illegal
);

    logic [OPC_W-1:0] opc_s;
    logic             imm_sel_s;
    logic [RW-1:0]    rd_s;
    ctrl_t            ctrl_s;
    logic [N-1:0]     imm_s;
    logic [N-1:0]     rs1_val_s;
    logic [N-1:0]     rs2_val_s;
    logic [N-1:0]     src_a_s;
    logic [N-1:0]     src_b_s;
    logic             load_en_s;
    logic             hazard_s;
    logic             xfer_s;

    assign opc_s     = instr[OPC_LSB +: OPC_W];
    assign imm_sel_s = instr[IMM_BIT];
    assign rd_s      = instr[RD_LSB +: RW];
    assign rs1_addr  = instr[RS1_LSB +: RW];
    assign rs2_addr  = instr[RS2_LSB +: RW];
    assign imm_s     = {{(N-IMM_W){instr[IMM_LSB+IMM_W-1]}}, instr[IMM_LSB +: IMM_W]};
    assign ctrl_s    = decode(opc_s, imm_sel_s);

    fwd_mux #(.N(N), .RW(RW)) u_fwd_a (
        .rs        (rs1_addr),
        .rf_data   (rd1),
        .fwd1_en   (fwd1_en),
        .fwd1_rd   (fwd1_rd),
        .fwd1_data (fwd1_data),
        .fwd2_en   (fwd2_en),
        .fwd2_rd   (fwd2_rd),
        .fwd2_data (fwd2_data),
        .sel_data  (rs1_val_s)
    );

    fwd_mux #(.N(N), .RW(RW)) u_fwd_b (
        .rs        (rs2_addr),
        .rf_data   (rd2),
        .fwd1_en   (fwd1_en),
        .fwd1_rd   (fwd1_rd),
        .fwd1_data (fwd1_data),
        .fwd2_en   (fwd2_en),
        .fwd2_rd   (fwd2_rd),
        .fwd2_data (fwd2_data),
        .sel_data  (rs2_val_s)
    );

    // Operand steering: immediate vs forwarded register value
    always_comb begin
        src_a_s = rs1_val_s;
        src_b_s = rs2_val_s;
        if (ctrl_s.a_is_imm) begin
            src_a_s = imm_s;
        end else begin
            src_a_s = rs1_val_s;
        end
        if (ctrl_s.b_is_imm) begin
            src_b_s = imm_s;
        end else begin
            src_b_s = rs2_val_s;
        end
    end

    // Load-use hazard: a held load's result is not yet available to a reader
    always_comb begin
        hazard_s = 1'b0;
        if (out_valid && mem_rd && reg_wr && in_valid) begin
            hazard_s = (ctrl_s.uses_rs1 && (dest == rs1_addr)) ||
                       (ctrl_s.uses_rs2 && (dest == rs2_addr));
        end else begin
            hazard_s = 1'b0;
        end
    end

    // Handshake: flush always drains the input, reset blocks it
    always_comb begin
        load_en_s = !out_valid || out_ready;
        in_ready  = 1'b0;
        if (rst) begin
            in_ready = 1'b0;
        end else if (flush) begin
            in_ready = 1'b1;
        end else begin
            in_ready = load_en_s && !hazard_s;
        end
        xfer_s = in_valid && in_ready && !flush;
    end

    // Output pipeline register; bubbles only clear out_valid, payload holds
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            alu_ctrl  <= 5'd0;
            src_A     <= '0;
            src_B     <= '0;
            dest      <= '0;
            reg_wr    <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            is_branch <= 1'b0;
            illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            illegal   <= 1'b0;
        end else if (load_en_s) begin
            out_valid <= xfer_s && ctrl_s.legal;
            illegal   <= xfer_s && !ctrl_s.legal;
            if (xfer_s && ctrl_s.legal) begin
                alu_ctrl  <= opc_s;
                src_A     <= src_a_s;
                src_B     <= src_b_s;
                dest      <= rd_s;
                reg_wr    <= ctrl_s.reg_wr;
                mem_rd    <= ctrl_s.mem_rd;
                mem_wr    <= ctrl_s.mem_wr;
                is_branch <= ctrl_s.is_branch;
            end else begin
                alu_ctrl  <= alu_ctrl;
                src_A     <= src_A;
                src_B     <= src_B;
                dest      <= dest;
                reg_wr    <= reg_wr;
                mem_rd    <= mem_rd;
                mem_wr    <= mem_wr;
                is_branch <= is_branch;
            end
        end else begin
            illegal <= 1'b0;
        end
    end

endmodule
